// File: rtl/data_mem_ctrl.sv
// Load/store controller between the core data port and a word-organised synchronous RAM.
// Optional build macro MISALIGN_TRAP_EN: reject misaligned H/W accesses instead of aligning them.
module data_mem_ctrl #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic [2:0]    funct3,
    input  logic [31:0]   dAdress,
    input  logic [31:0]   dWriteData,
    output logic [31:0]   dReadData,
    output logic          done,
    output logic          busy,
    output logic          fault,
    output logic [AW-1:0] ram_addr,
    output logic          ram_re,
    output logic          ram_we,
    output logic [3:0]    ram_be,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

    state_t        r_state;
    logic [1:0]    r_lane;
    logic [2:0]    r_funct3;
    logic          r_isLoad;
    logic [31:0]   r_dReadData;
    logic          r_done;
    logic          r_fault;
    logic [AW-1:0] r_ramAddr;
    logic          r_ramRe;
    logic          r_ramWe;
    logic [3:0]    r_ramBe;
    logic [31:0]   r_ramWdata;

    logic          w_request;
    logic          w_isByte;
    logic          w_isHalf;
    logic          w_isWord;
    logic          w_illegal;
    logic          w_misaligned;
    logic          w_reject;
    logic [1:0]    w_lane;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_shifted;
    logic [31:0]   w_loadValue;
    logic          w_unusedBits;

    assign w_request = MemRead | MemWrite;
    assign w_isByte  = (funct3[1:0] == 2'b00);
    assign w_isHalf  = (funct3[1:0] == 2'b01);
    assign w_isWord  = (funct3 == 3'b010);

    // Encodings 011/111 share low bits 11; 110 is the only other unused code.
    assign w_illegal = (MemRead & MemWrite) | (funct3[1:0] == 2'b11) |
                       (funct3 == 3'b110) | (MemWrite & funct3[2]);

`ifdef MISALIGN_TRAP_EN
    assign w_misaligned = (w_isHalf & dAdress[0]) | (w_isWord & (|dAdress[1:0]));
    assign w_lane       = dAdress[1:0];
`else
    assign w_misaligned = 1'b0;
    assign w_lane       = {dAdress[1] & ~w_isWord, dAdress[0] & w_isByte};
`endif

    assign w_reject = w_illegal | w_misaligned;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = dWriteData;
        if (w_isByte) begin
            w_be    = 4'b0001 << w_lane;
            w_wdata = {4{dWriteData[7:0]}};
        end else if (w_isHalf) begin
            w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{dWriteData[15:0]}};
        end
    end

    // Halfword lanes are always even, so one byte-granular shift serves B and H.
    assign w_shifted = ram_rdata >> {r_lane, 3'b000};

    always_comb begin
        w_loadValue = ram_rdata;
        case (r_funct3[1:0])
            2'b00:   w_loadValue = {{24{w_shifted[7] & ~r_funct3[2]}}, w_shifted[7:0]};
            2'b01:   w_loadValue = {{16{w_shifted[15] & ~r_funct3[2]}}, w_shifted[15:0]};
            default: w_loadValue = ram_rdata;
        endcase
    end

    assign w_unusedBits = ^{dAdress[31:AW+2], w_shifted[31:16]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_lane      <= '0;
            r_funct3    <= '0;
            r_isLoad    <= 1'b0;
            r_dReadData <= '0;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
            r_ramAddr   <= '0;
            r_ramRe     <= 1'b0;
            r_ramWe     <= 1'b0;
            r_ramBe     <= '0;
            r_ramWdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_request) begin
                        r_lane      <= w_lane;
                        r_funct3    <= funct3;
                        r_isLoad    <= MemRead;
                        r_dReadData <= '0;
                        if (w_reject) begin
                            r_done  <= 1'b1;
                            r_fault <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_ramAddr  <= dAdress[AW+1:2];
                            r_ramBe    <= w_be;
                            r_ramWdata <= w_wdata;
                            r_ramRe    <= MemRead;
                            r_ramWe    <= MemWrite;
                            r_state    <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    r_ramRe <= 1'b0;
                    r_ramWe <= 1'b0;
                    if (r_isLoad) begin
                        r_state <= CAPTURE;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                CAPTURE: begin
                    r_dReadData <= w_loadValue;
                    r_done      <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    r_done      <= 1'b0;
                    r_fault     <= 1'b0;
                    r_dReadData <= '0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign dReadData = r_dReadData;
    assign done      = r_done;
    assign fault     = r_fault;
    assign ram_addr  = r_ramAddr;
    assign ram_re    = r_ramRe;
    assign ram_we    = r_ramWe;
    assign ram_be    = r_ramBe;
    assign ram_wdata = r_ramWdata;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: byte-array reference memory plus a word RAM attached to the DUT.
// Honours MISALIGN_TRAP_EN when the bench is built with the same macro as the design.
module tb_data_mem_ctrl;

    localparam int AW    = 10;
    localparam int BYTES = 4 * (1 << AW);
    localparam int OW    = 73 + AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          MemRead;
    logic          MemWrite;
    logic [2:0]    funct3;
    logic [31:0]   dAdress;
    logic [31:0]   dWriteData;
    logic [31:0]   dReadData;
    logic          done;
    logic          busy;
    logic          fault;
    logic [AW-1:0] ram_addr;
    logic          ram_re;
    logic          ram_we;
    logic [3:0]    ram_be;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    int checks   = 0;
    int failures = 0;

    logic        clearRam;
    logic [31:0] ramWords [0:(1<<AW)-1];
    logic [7:0]  refMem   [0:BYTES-1];

    data_mem_ctrl #(.AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .funct3     (funct3),
        .dAdress    (dAdress),
        .dWriteData (dWriteData),
        .dReadData  (dReadData),
        .done       (done),
        .busy       (busy),
        .fault      (fault),
        .ram_addr   (ram_addr),
        .ram_re     (ram_re),
        .ram_we     (ram_we),
        .ram_be     (ram_be),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mergeBe(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Synchronous word RAM: byte-enabled write, registered read.
    always @(posedge clk) begin
        if (clearRam) begin
            for (int i = 0; i < (1 << AW); i++) ramWords[i] <= '0;
        end else begin
            if (ram_we) ramWords[ram_addr] <= mergeBe(ramWords[ram_addr], ram_wdata, ram_be);
            if (ram_re) ram_rdata <= ramWords[ram_addr];
        end
    end

    function automatic int accSize(input logic [2:0] f);
        case (f[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic isReject(input logic rd, input logic wr, input logic [2:0] f,
                                      input logic [31:0] a);
        if (rd && wr) return 1'b1;
        if (f == 3'd3 || f == 3'd6 || f == 3'd7) return 1'b1;
        if (wr && f[2]) return 1'b1;
`ifdef MISALIGN_TRAP_EN
        if (accSize(f) == 2 && a[0]) return 1'b1;
        if (accSize(f) == 4 && a[1:0] != 2'b00) return 1'b1;
`else
        if (a[31] && 1'b0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] refLoad(input logic [2:0] f, input logic [31:0] ea);
        logic [31:0] v;
        int          n;
        n = accSize(f);
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = refMem[ea + i];
        if (!f[2] && n < 4)
            for (int j = 8*n; j < 32; j++) v[j] = v[8*n-1];
        return v;
    endfunction

    function automatic logic [OW-1:0] outputsNow();
        return {dReadData, done, busy, fault, ram_addr, ram_re, ram_we, ram_be, ram_wdata};
    endfunction

    // Drives one request, holds it until done, then checks timing, RAM strobes and result.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f,
                                 input logic [31:0] a, input logic [31:0] d, input string tag);
        int            size;
        int            expLat;
        int            lat;
        int            strobes;
        logic          reject;
        logic [31:0]   ea;
        logic [AW-1:0] expAddr;
        logic [3:0]    expBe;
        logic [31:0]   expWdata;
        logic [31:0]   expRead;
        size    = accSize(f);
        reject  = isReject(rd, wr, f, a);
        ea      = (a & 32'(BYTES - 1)) & ~32'(size - 1);
        expAddr = ea[AW+1:2];
        expBe   = '0;
        for (int i = 0; i < size; i++) expBe[ea[1:0] + i] = 1'b1;
        for (int i = 0; i < 4; i++) expWdata[8*i +: 8] = d[8*(i % size) +: 8];
        expRead = (rd && !reject) ? refLoad(f, ea) : 32'h0;
        expLat  = reject ? 1 : (wr ? 2 : 3);
        MemRead = rd; MemWrite = wr; funct3 = f; dAdress = a; dWriteData = d;
        lat = 0;
        strobes = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (ram_re || ram_we) begin
                strobes++;
                checks++;
                if (c != 1) begin
                    failures++;
                    $display("[TB] FAIL %s strobe_cycle got %0d expected 1", tag, c);
                end
                checks++;
                if ({ram_re, ram_we, ram_addr} !== {rd, wr, expAddr}) begin
                    failures++;
                    $display("[TB] FAIL %s re_we_addr got %b%b %h expected %b%b %h", tag,
                             ram_re, ram_we, ram_addr, rd, wr, expAddr);
                end
                checks++;
                if (ram_be !== expBe) begin
                    failures++;
                    $display("[TB] FAIL %s ram_be got %b expected %b", tag, ram_be, expBe);
                end
                if (wr) begin
                    checks++;
                    if (ram_wdata !== expWdata) begin
                        failures++;
                        $display("[TB] FAIL %s ram_wdata got %h expected %h", tag, ram_wdata, expWdata);
                    end
                end
            end
            if (done) begin
                lat = c;
                break;
            end
        end
        checks++;
        if (lat != expLat) begin
            failures++;
            $display("[TB] FAIL %s done_latency got %0d expected %0d", tag, lat, expLat);
        end
        checks++;
        if (strobes != (reject ? 0 : 1)) begin
            failures++;
            $display("[TB] FAIL %s strobe_count got %0d expected %0d", tag, strobes, reject ? 0 : 1);
        end
        checks++;
        if ({fault, busy} !== {reject, 1'b1}) begin
            failures++;
            $display("[TB] FAIL %s fault_busy got %b%b expected %b1", tag, fault, busy, reject);
        end
        checks++;
        if (dReadData !== expRead) begin
            failures++;
            $display("[TB] FAIL %s dReadData got %h expected %h", tag, dReadData, expRead);
        end
        MemRead = 1'b0;
        MemWrite = 1'b0;
        if (wr && !reject)
            for (int i = 0; i < size; i++) refMem[ea + i] = d[8*i +: 8];
        @(posedge clk); #1;
        checks++;
        if ({done, busy, fault} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL %s after_done got %b expected 000", tag, {done, busy, fault});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clearRam = 1'b0;
        checks++;
        if (outputsNow() !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got %h expected 0", outputsNow());
        end
        rst = 1'b0;
    endtask

    task automatic test_word();
        applyStimulus(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, "sw_10");
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, "lw_10");
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_4010, 32'h0, "lw_wrap");
    endtask

    task automatic test_byte();
        applyStimulus(1'b0, 1'b1, 3'b000, 32'h13, 32'h0000_0080, "sb_13");
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, "lb_13");
        applyStimulus(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, "lbu_13");
    endtask

    task automatic test_half();
        applyStimulus(1'b0, 1'b1, 3'b001, 32'h22, 32'h0000_8001, "sh_22");
        applyStimulus(1'b1, 1'b0, 3'b001, 32'h22, 32'h0, "lh_22");
        applyStimulus(1'b1, 1'b0, 3'b101, 32'h22, 32'h0, "lhu_22");
    endtask

    task automatic test_reject();
        applyStimulus(1'b1, 1'b0, 3'b011, 32'h10, 32'h0, "funct3_011");
        applyStimulus(1'b1, 1'b1, 3'b010, 32'h10, 32'h1234_5678, "rd_and_wr");
        applyStimulus(1'b0, 1'b1, 3'b100, 32'h10, 32'h1234_5678, "store_bu");
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, "lw_after_rejects");
    endtask

    task automatic test_misalign();
        applyStimulus(1'b0, 1'b1, 3'b010, 32'h100, 32'h1122_3344, "sw_100");
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, "lw_102");
        applyStimulus(1'b1, 1'b0, 3'b001, 32'h103, 32'h0, "lh_103");
        applyStimulus(1'b0, 1'b1, 3'b001, 32'h101, 32'h0000_A5A5, "sh_101");
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, "lw_100");
    endtask

    task automatic test_reset_mid_store();
        MemWrite = 1'b1; MemRead = 1'b0; funct3 = 3'b010;
        dAdress = 32'h200; dWriteData = 32'hCAFE_F00D;
        @(posedge clk); #1;
        checks++;
        if (ram_we !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_store_we got %b expected 1", ram_we);
        end
        rst = 1'b1;
        MemWrite = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) refMem[32'h200 + i] = dWriteData[8*i +: 8];
        checks++;
        if (outputsNow() !== '0) begin
            failures++;
            $display("[TB] FAIL mid_store_outputs got %h expected 0", outputsNow());
        end
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, "lw_after_store_reset");
    endtask

    task automatic test_reset_mid_load();
        int doneSeen;
        MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; dAdress = 32'h10; dWriteData = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, ram_re} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL capture_cycle got %b expected 100", {busy, done, ram_re});
        end
        rst = 1'b1;
        MemRead = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (outputsNow() !== '0) begin
            failures++;
            $display("[TB] FAIL mid_load_outputs got %h expected 0", outputsNow());
        end
        doneSeen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done || busy) doneSeen++;
        end
        checks++;
        if (doneSeen != 0) begin
            failures++;
            $display("[TB] FAIL mid_load_quiet got %0d expected 0", doneSeen);
        end
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, "lw_after_load_reset");
    endtask

    // Back-to-back random traffic over a small window, with random high bits to exercise wrap.
    task automatic test_back_to_back();
        logic        rd;
        logic        wr;
        logic [2:0]  f;
        logic [31:0] a;
        int          sel;
        for (int n = 0; n < 160; n++) begin
            sel = $urandom_range(0, 19);
            rd  = (sel == 0) || (sel >= 1 && sel <= 9);
            wr  = (sel == 0) || (sel >= 10);
            f   = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0 && f != 3'b010 && wr) f = 3'($urandom_range(0, 2));
            a   = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            if (n % 5 == 0) a = a | 32'h0000_0FC0;
            applyStimulus(rd, wr, f, a, $urandom, $sformatf("rand_%0d", n));
        end
    endtask

    initial begin
        rst = 1'b1;
        clearRam = 1'b1;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        funct3 = 3'b000;
        dAdress = '0;
        dWriteData = '0;
        for (int i = 0; i < BYTES; i++) refMem[i] = 8'h00;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_reject();
        test_misalign();
        test_reset_mid_store();
        test_reset_mid_load();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Load/store controller between the `multicycle` core's data port and the word-organised synchronous data RAM. It accepts one byte, halfword or word access request at a time and generates the word address, byte enables and lane-replicated write data for the RAM. For loads it extracts the addressed lane and sign- or zero-extends it. The core holds its request until a one-cycle `done` pulse, and illegal or misaligned accesses are flagged on `fault`.

## Interface
- `AW`, default 10, RAM word-address width; the RAM holds 2^AW 32-bit words.

- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `MemRead`  in  1  load request; level, held until `done`
- `MemWrite`  in  1  store request; level, held until `done`
- `funct3`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; stores use 000/001/010 only
- `dAdress`  in  32  byte address
- `dWriteData`  in  32  store data, right-aligned
- `dReadData`  out  32  extended load result; valid while `done`=1
- `done`  out  1  one-cycle completion pulse
- `busy`  out  1  high whenever the FSM is not in IDLE
- `fault`  out  1  high with `done` when the access was rejected
- `ram_addr`  out  AW  word address, equal to `dAdress[AW+1:2]`
- `ram_re`  out  1  RAM read strobe
- `ram_we`  out  1  RAM write strobe
- `ram_be`  out  4  byte enables; bit i enables `ram_wdata[8i+7:8i]`
- `ram_wdata`  out  32  lane-replicated store data
- `ram_rdata`  in  32  RAM read data, valid in the cycle after `ram_re`

## Operation
- FSM states: IDLE, ACCESS, CAPTURE, DONE.
- Requests are accepted only in IDLE. Request inputs are ignored in every other state.
- IDLE, accepting a request:
  - Registers `dAdress`, `funct3` and `dWriteData`.
  - Next state is ACCESS, or DONE with fault if the request is rejected.
- A request is rejected (fault=1, no RAM strobe) when any of the following holds:
  - `MemRead` and `MemWrite` are both high.
  - `funct3` is 011, 110 or 111.
  - A store uses `funct3` 100 or 101.
- ACCESS:
  - `ram_re` or `ram_we` is high for exactly this cycle, with `ram_addr`, `ram_be` and `ram_wdata` driven from the registered request.
  - Next state: CAPTURE for loads, DONE for stores.
- CAPTURE: `ram_rdata` is valid. The lane is extracted, extended and registered into `dReadData`. Next state is DONE.
- DONE: `done`=1 for one cycle, then return to IDLE.
  - `dReadData` holds the load result, or 0 for stores and faults.
- Byte enables and store data:
  - B: `ram_be` = 1 << a[1:0]; `ram_wdata` = {4{d[7:0]}}.
  - H: `ram_be` = a[1] ? 1100 : 0011; `ram_wdata` = {2{d[15:0]}}.
  - W: `ram_be` = 1111; `ram_wdata` = d.
- Load extraction:
  - Lane = `ram_rdata` >> (8·a[1:0]) for B, and >> (16·a[1]) for H.
  - Sign-extend unless `funct3[2]`=1.
- Address bits above AW+1 are ignored, so addresses wrap modulo 2^(AW+2) bytes.

## Timing
- Reset value of every output is 0. State resets to IDLE.
- Request accepted at edge N (sampled in IDLE):
  - ACCESS in cycle N+1.
  - Store: `done` in cycle N+2.
  - Load: CAPTURE in N+2, `done` with data in N+3.
  - Rejected request: `done`+`fault` in N+1.
- Throughput:
  - Back-to-back requests are accepted in the cycle after DONE.
  - The core must drop `MemRead`/`MemWrite` in the cycle after `done`, or the request is accepted again.
- Reset during an access:
  - If `rst` is high in the ACCESS cycle, the RAM still writes at that edge.
  - After any mid-access reset the transaction is discarded and no `done` is issued.
- `busy` is combinational from the state register. It is never high in the same cycle as an IDLE acceptance.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - H with a[0]=1, or W with a[1:0]≠00, is rejected: `done`+`fault` in N+1, no RAM access.
- `MISALIGN_TRAP_EN` undefined:
  - The low address bits are forced to natural alignment: a[0] is cleared for H, a[1:0] for W.
  - The access proceeds normally; misalignment never raises `fault`.

## Test plan
- Reset, then store W 0xDEADBEEF at 0x10 and load W from 0x10 → `ram_addr`=4, `ram_be`=1111; load returns 0xDEADBEEF with `done` at N+3.
- Store B 0x80 at 0x13, then LB and LBU at 0x13 → `ram_be`=1000, `ram_wdata`=0x80808080; LB returns 0xFFFFFF80, LBU returns 0x00000080.
- Store H 0x8001 at 0x22, then LH and LHU → `ram_be`=1100; LH returns 0xFFFF8001, LHU returns 0x00008001.
- `funct3`=011, and separately `MemRead`=`MemWrite`=1 → `done`+`fault` at N+1, `ram_we`=`ram_re`=0, `dReadData`=0.
- LW at 0x102, covering both configurations:
  - Built with `MISALIGN_TRAP_EN`: `fault` at N+1.
  - Built without it: reads word 0x40 with no fault.
- Assert `rst` during the CAPTURE cycle of a load → no `done`; FSM in IDLE; all outputs 0 next cycle; the next request completes normally.
